// File: rtl/riscv_pkg.sv
// Shared types for the multicycle core's memory-port arbiter: FSM states,
// port owner encoding and the machine word width.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Winner select for the shared memory port: data has priority, but a pending
// fetch is forced through after D_BURST_MAX consecutive data grants.
module mem_arb_select
  import riscv_pkg::*;
#(
  parameter int D_BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_arb_en,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_if_win,
  output logic o_d_win
);

  localparam int CNT_W = $clog2(D_BURST_MAX + 1);

  logic [CNT_W-1:0] r_burst_cnt;
  logic             w_burst_full;

  assign w_burst_full = (r_burst_cnt == CNT_W'(D_BURST_MAX));
  assign o_if_win     = i_arb_en & i_if_req & (~i_d_req | w_burst_full);
  assign o_d_win      = i_arb_en & i_d_req & ~o_if_win;

  // Counts data grants taken while fetch was waiting; any fetch grant, or a
  // data grant with no fetch pending, starts the window over.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (o_if_win) begin
      r_burst_cnt <= '0;
    end else if (o_d_win) begin
      if (!i_if_req)
        r_burst_cnt <= '0;
      else if (!w_burst_full)
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between fetch and mem stages: one outstanding
// req/gnt/rvalid transaction, response routed to its owner, flushable fetches.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int D_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_owner_t        r_owner;
  logic              r_drop;
  logic              r_mem_we;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [XLEN/8-1:0] r_mem_wstrb;
  logic              r_if_rvalid;
  logic [XLEN-1:0]   r_if_rdata;
  logic              r_d_rvalid;
  logic [XLEN-1:0]   r_d_rdata;

  logic w_arb_en;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_resp;
  logic w_flush_hit;

  // Grants are combinational, so they must be masked directly while reset is low.
  assign w_arb_en = (r_state == IDLE) & rst_n;

  mem_arb_select #(
    .D_BURST_MAX (D_BURST_MAX)
  ) u_select (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_arb_en (w_arb_en),
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .o_if_win (w_if_gnt),
    .o_d_win  (w_d_gnt)
  );

  // A response only counts once the memory has accepted the request.
  assign w_resp      = mem_rvalid & (((r_state == REQ) & mem_gnt) | (r_state == WAIT));
  assign w_flush_hit = if_flush & (r_owner == FETCH) & ((r_state == REQ) | (r_state == WAIT));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the hold-current-state default comes first so no path leaves
  // w_state_nxt unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_if_gnt || w_d_gnt) w_state_nxt = REQ;
      REQ:     if (mem_gnt) w_state_nxt = mem_rvalid ? IDLE : WAIT;
      WAIT:    if (mem_rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner     <= NONE;
      r_drop      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;

      if (w_if_gnt) begin
        r_owner     <= FETCH;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
        r_mem_wstrb <= '0;
        r_drop      <= if_flush;
      end else if (w_d_gnt) begin
        r_owner     <= DATA;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_we ? d_wdata : '0;
        r_mem_wstrb <= d_we ? d_wstrb : '0;
        r_drop      <= 1'b0;
      end

      if (w_flush_hit) r_drop <= 1'b1;

      // A flush in the response cycle itself still suppresses the pulse.
      if (w_resp) begin
        if (r_owner == FETCH) begin
          r_if_rdata  <= mem_rdata;
          r_if_rvalid <= ~(r_drop | if_flush);
        end else if (r_owner == DATA) begin
          r_d_rdata  <= mem_rdata;
          r_d_rvalid <= 1'b1;
        end
        r_owner <= NONE;
        r_drop  <= 1'b0;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = (r_state == REQ);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule
